div_handshake: RTL and testbench

DIV_HANDSHAKE -- requirements
Module: div_handshake

---
 rtl/div_handshake.sv | 127 ++++++++++++
 tb/tb_div_handshake.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_handshake.sv
// Valid/ready wrapper around a combinational divider: operands are registered on
// acceptance, the divider is given LATENCY cycles to settle, then the result is held until taken.

module div_comb #(
    parameter int DIVIDEND = 6,
    parameter int DIVISOR  = 3
) (
    input  logic [DIVIDEND-1:0] dividend,
    input  logic [DIVISOR-1:0]  divisor,
    output logic [DIVIDEND-1:0] quotient,
    output logic [DIVISOR-1:0]  remainder
);
    logic [DIVISOR:0] rem;

    // Restoring long division; the partial remainder needs one guard bit.
    always_comb begin
        rem      = '0;
        quotient = '0;
        for (int i = DIVIDEND - 1; i >= 0; i--) begin
            rem = {rem[DIVISOR-1:0], dividend[i]};
            if (rem >= {1'b0, divisor}) begin
                rem         = rem - {1'b0, divisor};
                quotient[i] = 1'b1;
            end
        end
        remainder = rem[DIVISOR-1:0];
    end
endmodule

// Handshake semantics: a transfer happens at a rising edge where valid and ready are
// both 1; valid never depends on ready, and a producer holds its data until transfer.
module div_handshake #(
    parameter int DIVIDEND = 6,
    parameter int DIVISOR  = 3,
    parameter int LATENCY  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DIVIDEND-1:0] in_dividend,
    input  logic [DIVISOR-1:0]  in_divisor,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DIVIDEND-1:0] out_quotient,
    output logic [DIVISOR-1:0]  out_remainder,
    output logic                out_dbz,
    output logic                busy,
    output logic [1:0]          fsm_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    logic [3:0]          count;
    logic [DIVIDEND-1:0] op_dividend;
    logic [DIVISOR-1:0]  op_divisor;
    logic [DIVIDEND-1:0] div_quotient;
    logic [DIVISOR-1:0]  div_remainder;
    logic                take;

    div_comb #(
        .DIVIDEND(DIVIDEND),
        .DIVISOR (DIVISOR)
    ) u_div (
        .dividend (op_dividend),
        .divisor  (op_divisor),
        .quotient (div_quotient),
        .remainder(div_remainder)
    );

    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign take      = in_valid && in_ready;
    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            count         <= '0;
            op_dividend   <= '0;
            op_divisor    <= '0;
            out_valid     <= 1'b0;
            out_quotient  <= '0;
            out_remainder <= '0;
            out_dbz       <= 1'b0;
        end else if (take) begin
            // A zero divisor spends a single cycle in WAIT so its result is
            // presented one edge after the transfer, without waiting for the divider.
            op_dividend <= in_dividend;
            op_divisor  <= in_divisor;
            count       <= (in_divisor == '0) ? 4'd0 : 4'(LATENCY - 1);
            out_valid   <= 1'b0;
            state       <= S_WAIT;
        end else begin
            unique case (state)
                S_WAIT: begin
                    if (count == 4'd0) begin
                        if (op_divisor == '0) begin
                            out_quotient  <= '1;
                            out_remainder <= '0;
                            out_dbz       <= 1'b1;
                        end else begin
                            out_quotient  <= div_quotient;
                            out_remainder <= div_remainder;
                            out_dbz       <= 1'b0;
                        end
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_handshake.sv
// Self-checking bench for div_handshake: directed scenarios, exhaustive sweep and
// a randomized stall test scored against an integer-division model.

module tb_div_handshake;
    localparam int DW  = 6;
    localparam int SW  = 3;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_dividend;
    logic [SW-1:0] in_divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_quotient;
    logic [SW-1:0] out_remainder;
    logic          out_dbz;
    logic          busy;
    logic [1:0]    fsm_state;

    int checks = 0;
    int errors = 0;
    logic [DW+SW:0] exp_q[$];

    div_handshake #(.DIVIDEND(DW), .DIVISOR(SW), .LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_remainder(out_remainder),
        .out_dbz      (out_dbz),
        .busy         (busy),
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer division, zero divisor gives all-ones / 0 / dbz.
    function automatic logic [DW+SW:0] model(input int a, input int b);
        if (b == 0) return {1'b1, {DW{1'b1}}, {SW{1'b0}}};
        return {1'b0, DW'(a / b), SW'(a % b)};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [SW-1:0] b);
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        #1;
        for (int t = 0; t < 50 && !in_ready; t++) cycle();
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_dividend = '0; in_divisor = '0;
        cycle(); cycle();
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if ({out_dbz, out_quotient, out_remainder} !== '0) begin errors++;
            $display("FAIL reset_outputs: got q=%0d r=%0d dbz=%0b want 0 0 0", out_quotient, out_remainder, out_dbz); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(6'd45, 3'd6);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL basic_wait: out_valid=%0b in_ready=%0b busy=%0b want 0 0 1", out_valid, in_ready, busy); end
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early: out_valid=%0b want 0", out_valid); end
        cycle();
        checks++; if (out_valid !== 1'b1 || out_quotient !== 6'd7 || out_remainder !== 3'd3 || out_dbz !== 1'b0) begin errors++;
            $display("FAIL basic_result: v=%0b q=%0d r=%0d dbz=%0b want 1 7 3 0", out_valid, out_quotient, out_remainder, out_dbz); end
        cycle();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL basic_retire: out_valid=%0b busy=%0b want 0 0", out_valid, busy); end
    endtask

    task automatic test_dbz();
        out_ready = 1'b1;
        send(6'd20, 3'd0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dbz_early: out_valid=%0b want 0", out_valid); end
        cycle();
        checks++; if (out_valid !== 1'b1 || out_quotient !== 6'd63 || out_remainder !== 3'd0 || out_dbz !== 1'b1) begin errors++;
            $display("FAIL dbz_result: v=%0b q=%0d r=%0d dbz=%0b want 1 63 0 1", out_valid, out_quotient, out_remainder, out_dbz); end
        cycle();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL dbz_retire: out_valid=%0b busy=%0b want 0 0", out_valid, busy); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(6'd63, 3'd7);
        cycle(); cycle();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_quotient !== 6'd9 || out_remainder !== 3'd0 || out_dbz !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: v=%0b q=%0d r=%0d dbz=%0b in_ready=%0b want 1 9 0 0 0",
                         i, out_valid, out_quotient, out_remainder, out_dbz, in_ready);
            end
            cycle();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %0b want 1", in_ready); end
        cycle();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL hold_retire: out_valid=%0b busy=%0b want 0 0", out_valid, busy); end
    endtask

    task automatic test_back_to_back();
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_dividend = 6'd10;
        in_divisor  = 3'd3;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_first_ready: got %0b want 1", in_ready); end
        cycle();
        in_dividend = 6'd17;
        in_divisor  = 3'd5;
        cycle(); cycle();
        checks++; if (out_valid !== 1'b1 || out_quotient !== 6'd3 || out_remainder !== 3'd1 || in_ready !== 1'b1) begin errors++;
            $display("FAIL b2b_first: v=%0b q=%0d r=%0d in_ready=%0b want 1 3 1 1", out_valid, out_quotient, out_remainder, in_ready); end
        cycle();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL b2b_no_gap: out_valid=%0b busy=%0b want 0 1", out_valid, busy); end
        cycle(); cycle();
        checks++; if (out_valid !== 1'b1 || out_quotient !== 6'd3 || out_remainder !== 3'd2 || out_dbz !== 1'b0) begin errors++;
            $display("FAIL b2b_second: v=%0b q=%0d r=%0d dbz=%0b want 1 3 2 0", out_valid, out_quotient, out_remainder, out_dbz); end
        cycle();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL b2b_retire: out_valid=%0b busy=%0b want 0 0", out_valid, busy); end
    endtask

    task automatic test_reset_inflight();
        out_ready = 1'b1;
        send(6'd30, 3'd4);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++;
            $display("FAIL abort_state: in_ready=%0b busy=%0b out_valid=%0b want 1 0 0", in_ready, busy, out_valid); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_quiet_%0d: out_valid=%0b want 0", i, out_valid); end
            cycle();
        end
        // Reset wins over a transfer offered at the same edge.
        in_valid = 1'b1; in_dividend = 6'd9; in_divisor = 3'd2; reset = 1'b1;
        cycle();
        reset = 1'b0; in_valid = 1'b0;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_priority: busy=%0b out_valid=%0b want 0 0", busy, out_valid); end
        cycle(); cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_priority_quiet: out_valid=%0b want 0", out_valid); end
    endtask

    task automatic test_sweep();
        logic [8:0]      v;
        logic [DW+SW:0]  exp;
        int              lat;
        out_ready = 1'b1;
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            exp_q.push_back(model(int'(v[5:0]), int'(v[8:6])));
            send(v[5:0], v[8:6]);
            lat = 0;
            while (!out_valid && lat < 20) begin
                cycle();
                lat++;
            end
            exp = exp_q.pop_front();
            checks++;
            if (lat !== ((v[8:6] == 3'd0) ? 1 : LAT)) begin
                errors++;
                $display("FAIL sweep_latency %0d/%0d: got %0d cycles want %0d", v[5:0], v[8:6], lat, (v[8:6] == 3'd0) ? 1 : LAT);
            end
            checks++;
            if ({out_dbz, out_quotient, out_remainder} !== exp) begin
                errors++;
                $display("FAIL sweep_result %0d/%0d: got q=%0d r=%0d dbz=%0b want q=%0d r=%0d dbz=%0b",
                         v[5:0], v[8:6], out_quotient, out_remainder, out_dbz, exp[DW+SW-1:SW], exp[SW-1:0], exp[DW+SW]);
            end
            cycle();
        end
    endtask

    task automatic test_random();
        int             sent = 0;
        int             got  = 0;
        int             budget = 0;
        logic           accepted;
        logic [DW+SW:0] exp;
        exp_q.delete();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        while (got < 150 && budget < 6000) begin
            if (!in_valid && sent < 150 && $urandom_range(0, 3) != 0) begin
                in_valid    = 1'b1;
                in_dividend = DW'($urandom_range(0, 63));
                in_divisor  = SW'($urandom_range(0, 7));
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            accepted = 1'b0;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(int'(in_dividend), int'(in_divisor)));
                sent++;
                accepted = 1'b1;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL random_unexpected: got q=%0d r=%0d with no pending operation", out_quotient, out_remainder);
                end else begin
                    exp = exp_q.pop_front();
                    if ({out_dbz, out_quotient, out_remainder} !== exp) begin
                        errors++;
                        $display("FAIL random_result #%0d: got q=%0d r=%0d dbz=%0b want q=%0d r=%0d dbz=%0b",
                                 got, out_quotient, out_remainder, out_dbz, exp[DW+SW-1:SW], exp[SW-1:0], exp[DW+SW]);
                    end
                end
                got++;
            end
            cycle();
            if (accepted) in_valid = 1'b0;
            budget++;
        end
        checks++;
        if (got != 150) begin
            errors++;
            $display("FAIL random_timeout: retired %0d results, required 150", got);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle(); cycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dbz();
        test_backpressure();
        test_back_to_back();
        test_reset_inflight();
        test_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
